hcount_frame_accum: RTL
=======================

// Module: hcount_frame_accum
// PURPOSE
//  Consumer end of the 32-lane h_plus/h_minus count interface. Takes one pair of
//  per-beat lane counts per handshake and accumulates a frame (ended by in_last).
//  It then presents the frame totals, their signed difference and the beat count
//  on a valid/ready output, with sticky overflow and range flags.
//  Sits directly downstream of the 32-lane counter array, feeding the decision logic.
// PARAMETERS
//  LANES  32  lanes per beat; the largest legal per-beat count
//  CW     7   per-beat count width (>= clog2(LANES+1))
//  AW     16  accumulator width for sum_plus/sum_minus
//  BW     10  beat counter width
// PORTS
//  clk         in   1      clock, all state changes on the rising edge
//  rst         in   1      synchronous reset, active-high
//  in_valid    in   1      beat counts are valid
//  in_ready    out  1      block can accept a beat
//  in_last     in   1      accepted beat is the last beat of the frame
//  h_plus_in   in   CW     h_plus count for this beat
//  h_minus_in  in   CW     h_minus count for this beat
//  out_valid   out  1      frame result valid
//  out_ready   in   1      downstream takes the result
//  sum_plus    out  AW     sum of h_plus over the frame
//  sum_minus   out  AW     sum of h_minus over the frame
//  diff        out  AW+1   signed, sum_plus - sum_minus
//  beats       out  BW     number of beats accepted in the frame
//  ovf         out  1      a sum or the beat counter saturated this frame
//  range_err   out  1      some beat had an input count > LANES this frame
// BEHAVIOUR
//  - Reset: state=IDLE; all sums, diff, beats, ovf, range_err and out_valid = 0.
//    in_ready=0 in any cycle where rst=1. Reset aborts a frame in progress with no output.
//  - FSM IDLE -> ACC -> DONE -> IDLE.
//    IDLE: on the first accepted beat go to ACC, or go straight to DONE if in_last=1.
//    ACC: stays in ACC until the accepted beat has in_last=1, then goes to DONE.
//    DONE: on out_valid && out_ready, clear all accumulators and go to IDLE.
//  - in_ready = !rst && (state != DONE). It is a combinational function of state only.
//  - Accept happens when in_valid && in_ready.
//    On accept: sums += per-beat counts, beats += 1, sticky flags are updated.
//    No accept means every accumulator holds its value; gaps in in_valid are legal.
//  - Per-beat count above LANES: clamp it to LANES before adding and set range_err.
//  - Sums saturate at 2^AW-1 and beats saturates at 2^BW-1; either saturation sets ovf.
//    ovf and range_err are sticky until the frame completes.
//  - diff is registered with the sums and sign-extended: {1'b0,sum_plus}-{1'b0,sum_minus}.
//  - Latency: out_valid rises on the cycle after the in_last beat is accepted.
//    The outputs include that last beat.
//  - While out_valid=1 && out_ready=0, every output holds stable and in_ready=0.
//  - Completion costs one bubble: IDLE, with in_ready=1, follows the out_ready cycle.
//  - out_ready is ignored while out_valid=0.
//  - In IDLE and ACC the sum outputs show the running totals, but they are
//    meaningful only while out_valid=1.
// TESTING
//  1. Reset, then one beat (5,3,last) -> next cycle: out_valid=1, sum_plus=5,
//     sum_minus=3, diff=+2, beats=1, ovf=0, range_err=0.
//  2. Beats (32,0),(0,32),(10,20),(7,7,last), with 2 idle cycles between beats 2 and 3
//     -> 49/59, diff=-10, beats=4.
//  3. Complete a frame, hold out_ready=0 for 5 cycles while driving in_valid=1
//     -> outputs stable, in_ready=0, nothing absorbed.
//     Then out_ready=1 -> IDLE; the next frame (1,1,last) gives 1/1/0/1.
//  4. AW=8: 9 beats of (32,0) -> sum_plus=255, ovf=1, diff=+255, beats=9.
//     The following frame shows ovf=0.
//  5. Beat (40,2,last) with LANES=32 -> sum_plus=32, range_err=1, diff=+30.
//  6. Two beats (4,4),(4,4), then rst=1 for 1 cycle mid-frame -> out_valid=0, sums 0.
//     The next frame (2,9,last) -> diff=-7, beats=1.

Source files
------------

// File: rtl/hcount_frame_accum.sv
// Frame accumulator for the 32-lane h_plus/h_minus counters: sums per-beat counts over
// a frame and hands the totals, their difference and the beat count to the decision logic.
module hcount_frame_accum #(
    parameter int LANES = 32,
    parameter int CW    = 7,
    parameter int AW    = 16,
    parameter int BW    = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_last,
    input  logic [CW-1:0]        h_plus_in,
    input  logic [CW-1:0]        h_minus_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [AW-1:0]        sum_plus,
    output logic [AW-1:0]        sum_minus,
    output logic signed [AW:0]   diff,
    output logic [BW-1:0]        beats,
    output logic                 ovf,
    output logic                 range_err
);

    // state | meaning
    // IDLE  | no beat of the current frame accepted yet
    // ACC   | frame in progress, accumulating beats
    // DONE  | frame totals presented, waiting for out_ready
    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
    state_t state;

    localparam logic [CW-1:0] LANES_C = CW'(LANES);

    logic            accept;
    logic            plus_hi, minus_hi;
    logic [CW-1:0]   plus_c, minus_c;
    logic [AW:0]     plus_raw, minus_raw;
    logic [AW-1:0]   plus_nxt, minus_nxt;
    logic            plus_sat, minus_sat, beats_sat;

    assign in_ready = !rst && (state != DONE);
    assign accept   = in_valid && in_ready;

    // Clamped, saturating next-sum values; only committed on an accepted beat.
    always_comb begin
        plus_hi   = h_plus_in > LANES_C;
        minus_hi  = h_minus_in > LANES_C;
        plus_c    = plus_hi ? LANES_C : h_plus_in;
        minus_c   = minus_hi ? LANES_C : h_minus_in;
        plus_raw  = {1'b0, sum_plus} + (AW+1)'(plus_c);
        minus_raw = {1'b0, sum_minus} + (AW+1)'(minus_c);
        plus_sat  = plus_raw[AW];
        minus_sat = minus_raw[AW];
        plus_nxt  = plus_sat ? {AW{1'b1}} : plus_raw[AW-1:0];
        minus_nxt = minus_sat ? {AW{1'b1}} : minus_raw[AW-1:0];
        beats_sat = &beats;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sum_plus  <= '0;
            sum_minus <= '0;
            diff      <= '0;
            beats     <= '0;
            ovf       <= 1'b0;
            range_err <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE, ACC: begin
                    if (accept) begin
                        sum_plus  <= plus_nxt;
                        sum_minus <= minus_nxt;
                        diff      <= $signed({1'b0, plus_nxt}) - $signed({1'b0, minus_nxt});
                        beats     <= beats_sat ? beats : beats + 1'b1;
                        ovf       <= ovf | plus_sat | minus_sat | beats_sat;
                        range_err <= range_err | plus_hi | minus_hi;
                        out_valid <= in_last;
                        state     <= in_last ? DONE : ACC;
                    end
                end
                DONE: begin
                    // out_valid is always high here, so out_ready alone completes the handshake
                    if (out_ready) begin
                        sum_plus  <= '0;
                        sum_minus <= '0;
                        diff      <= '0;
                        beats     <= '0;
                        ovf       <= 1'b0;
                        range_err <= 1'b0;
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
